// File: rtl/tpu_mem_pkg.sv
// Shared constants, requester identities and request type for the TPU data-SRAM path.
package tpu_mem_pkg;

   localparam int SRAM_ADDR_W = 13;
   localparam int SRAM_DATA_W = 32;

   // Requester identities as wired onto the shared SRAM port.
   typedef enum logic [1:0] {
      REQ_HOST = 2'd0,
      REQ_VLSU = 2'd1,
      REQ_SA   = 2'd2
   } req_id_e;

   // One requester's access as seen by the SRAM port.
   typedef struct packed {
      logic                   we;
      logic [SRAM_ADDR_W-1:0] addr;
      logic [SRAM_DATA_W-1:0] wdata;
   } mem_req_t;

   // Width of an index into n requesters (at least one bit).
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester after last_grant, wrapping around.
module rr_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_grant,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx
);

   logic [IDX_W-1:0] scan_idx;

   // Scan from farthest to nearest so the requester right after last_grant wins.
   always_comb begin
      // NOTE: every output gets a default before the search, so no path can hold a stale value and infer a latch.
      grant     = '0;
      grant_idx = '0;
      scan_idx  = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         scan_idx = IDX_W'((32'(last_grant) + 32'(k)) % 32'(NUM_REQ));
         if (req[scan_idx]) begin
            grant           = '0;
            grant[scan_idx] = 1'b1;
            grant_idx       = scan_idx;
         end
      end
   end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM port among NUM_REQ requesters: round-robin with bounded bursts,
// zero-latency grant, and a read-latency pipeline that routes read data to its issuer.
module sram_port_arbiter
   import tpu_mem_pkg::*;
#(
   parameter int NUM_REQ      = 3,
   parameter int ADDR_W       = SRAM_ADDR_W,
   parameter int DATA_W       = SRAM_DATA_W,
   parameter int READ_LATENCY = 1,
   parameter int MAX_BURST    = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      sram_en,
   output logic                      sram_we,
   output logic [ADDR_W-1:0]         sram_addr,
   output logic [DATA_W-1:0]         sram_din,
   input  logic [DATA_W-1:0]         sram_dout
);

   localparam int               IDX_W     = idx_width(NUM_REQ);
   localparam int               CNT_W     = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

   // Arbitration state
   logic [IDX_W-1:0] last_grant_q, last_grant_d;
   logic [CNT_W-1:0] burst_cnt_q,  burst_cnt_d;
   logic             sticky_q,     sticky_d;

   // Read pipeline: stage 0 is loaded at acceptance, the last stage lines up with sram_dout
   logic [READ_LATENCY-1:0]            rd_vld_q, rd_vld_d;
   logic [READ_LATENCY-1:0][IDX_W-1:0] rd_id_q,  rd_id_d;

   // Grant path
   logic [NUM_REQ-1:0] rr_grant;
   logic [IDX_W-1:0]   rr_idx;
   logic [NUM_REQ-1:0] last_oh;
   logic               others_valid;
   logic               keep_last;
   logic               gnt_valid;
   logic [IDX_W-1:0]   gnt_idx;
   logic [NUM_REQ-1:0] gnt_oh;
   logic               gnt_read;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_arbiter (
      .req        (req_valid),
      .last_grant (last_grant_q),
      .grant      (rr_grant),
      .grant_idx  (rr_idx)
   );

   // Keep the current owner while its burst allowance lasts or nobody else is asking; otherwise rotate.
   always_comb begin
      last_oh               = '0;
      last_oh[last_grant_q] = 1'b1;
      others_valid          = |(req_valid & ~last_oh);
      keep_last             = req_valid[last_grant_q] &&
                              ((sticky_q && (burst_cnt_q < BURST_MAX)) || !others_valid);
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      gnt_oh    = '0;
      if (!rst) begin
         if (keep_last) begin
            gnt_valid = 1'b1;
            gnt_idx   = last_grant_q;
            gnt_oh    = last_oh;
         end else begin
            gnt_valid = |rr_grant;
            gnt_idx   = rr_idx;
            gnt_oh    = rr_grant;
         end
      end
      gnt_read = gnt_valid && !req_we[gnt_idx];
   end

   // Drive the SRAM port straight from the granted requester; idle port is all zeros.
   always_comb begin
      req_ready = gnt_oh;
      sram_en   = gnt_valid;
      sram_we   = 1'b0;
      sram_addr = '0;
      sram_din  = '0;
      if (gnt_valid) begin
         sram_we   = req_we[gnt_idx];
         sram_addr = req_addr[gnt_idx*ADDR_W +: ADDR_W];
         sram_din  = req_wdata[gnt_idx*DATA_W +: DATA_W];
      end
   end

   // Burst bookkeeping: a grant is always a transfer, since only a valid requester is ever granted.
   always_comb begin
      last_grant_d = last_grant_q;
      burst_cnt_d  = burst_cnt_q;
      sticky_d     = 1'b0;
      if (gnt_valid) begin
         sticky_d = 1'b1;
         if (gnt_idx == last_grant_q) begin
            if (burst_cnt_q < BURST_MAX) begin
               burst_cnt_d = burst_cnt_q + CNT_W'(1);
            end
         end else begin
            last_grant_d = gnt_idx;
            burst_cnt_d  = CNT_W'(1);
         end
      end else begin
         burst_cnt_d = '0;
      end
   end

   // Shift accepted reads down the latency pipeline, one stage per cycle.
   always_comb begin
      rd_vld_d    = '0;
      rd_id_d     = '0;
      rd_vld_d[0] = gnt_read;
      rd_id_d[0]  = gnt_idx;
      for (int i = 1; i < READ_LATENCY; i++) begin
         rd_vld_d[i] = rd_vld_q[i-1];
         rd_id_d[i]  = rd_id_q[i-1];
      end
   end

   // Return read data to its issuer when the pipeline output lines up with sram_dout.
   always_comb begin
      rsp_valid = '0;
      rsp_rdata = '0;
      if (!rst && rd_vld_q[READ_LATENCY-1]) begin
         rsp_valid[rd_id_q[READ_LATENCY-1]] = 1'b1;
         rsp_rdata                          = sram_dout;
      end
   end

   // Arbitration state and read-pipeline valid bits; reset drops any in-flight reads.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of statement order.
      if (rst) begin
         last_grant_q <= LAST_IDX;
         burst_cnt_q  <= '0;
         sticky_q     <= 1'b0;
         rd_vld_q     <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         burst_cnt_q  <= burst_cnt_d;
         sticky_q     <= sticky_d;
         rd_vld_q     <= rd_vld_d;
      end
   end

   // Issuer ids travelling alongside the read-pipeline valid bits.
   always_ff @(posedge clk) begin
      // NOTE: left unreset on purpose -- an id is only looked at when its valid bit is set, and those bits are reset.
      rd_id_q <= rd_id_d;
   end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench: two arbiters (read latency 1 and 2) share one randomized stimulus
// stream and are compared cycle by cycle against a rule-level reference model.
module tb_sram_port_arbiter;

   localparam int NUM_REQ   = 3;
   localparam int ADDR_W    = 13;
   localparam int DATA_W    = 32;
   localparam int MAX_BURST = 4;
   localparam int MAX_CYC   = 1024;
   localparam logic [DATA_W-1:0] POISON = 32'h0BAD_F00D;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Requester-side stimulus
   logic [NUM_REQ-1:0]        v;
   logic [NUM_REQ-1:0]        we;
   logic [ADDR_W-1:0]         addr [NUM_REQ];
   logic [DATA_W-1:0]         wd   [NUM_REQ];
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_wdata;

   always_comb begin
      req_addr  = '0;
      req_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_addr[i*ADDR_W +: ADDR_W]  = addr[i];
         req_wdata[i*DATA_W +: DATA_W] = wd[i];
      end
   end

   // Per-instance DUT outputs: index 0 has READ_LATENCY=1, index 1 has READ_LATENCY=2
   logic [NUM_REQ-1:0] ready  [2];
   logic [NUM_REQ-1:0] rsp_v  [2];
   logic [DATA_W-1:0]  rsp_d  [2];
   logic               s_en   [2];
   logic               s_we   [2];
   logic [ADDR_W-1:0]  s_addr [2];
   logic [DATA_W-1:0]  s_din  [2];
   logic [DATA_W-1:0]  s_dout [2];

   sram_port_arbiter #(
      .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(1), .MAX_BURST(MAX_BURST)
   ) u_dut_rl1 (
      .clk(clk), .rst(rst), .req_valid(v), .req_ready(ready[0]), .req_we(we),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_v[0]), .rsp_rdata(rsp_d[0]),
      .sram_en(s_en[0]), .sram_we(s_we[0]), .sram_addr(s_addr[0]), .sram_din(s_din[0]),
      .sram_dout(s_dout[0])
   );

   sram_port_arbiter #(
      .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(2), .MAX_BURST(MAX_BURST)
   ) u_dut_rl2 (
      .clk(clk), .rst(rst), .req_valid(v), .req_ready(ready[1]), .req_we(we),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_v[1]), .rsp_rdata(rsp_d[1]),
      .sram_en(s_en[1]), .sram_we(s_we[1]), .sram_addr(s_addr[1]), .sram_din(s_din[1]),
      .sram_dout(s_dout[1])
   );

   // Background memory contents; 0x0010 holds the well-known word
   function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] a);
      if (a == 13'h0010) return 32'hDEADBEEF;
      return {3'b101, a, ~a, 3'b011};
   endfunction

   // SRAM models driven by each DUT; output is poisoned whenever no read was issued
   bit   [DATA_W-1:0] mem_a [8192];
   bit                wr_a  [8192];
   bit   [DATA_W-1:0] mem_b [8192];
   bit                wr_b  [8192];
   logic [DATA_W-1:0] rd_a, rd_b1, rd_b2;

   always @(posedge clk) begin
      rd_a <= POISON;
      if (s_en[0]) begin
         if (s_we[0]) begin
            mem_a[s_addr[0]] <= s_din[0];
            wr_a[s_addr[0]]  <= 1'b1;
         end else begin
            rd_a <= wr_a[s_addr[0]] ? mem_a[s_addr[0]] : init_word(s_addr[0]);
         end
      end
   end

   always @(posedge clk) begin
      rd_b1 <= POISON;
      rd_b2 <= rd_b1;
      if (s_en[1]) begin
         if (s_we[1]) begin
            mem_b[s_addr[1]] <= s_din[1];
            wr_b[s_addr[1]]  <= 1'b1;
         end else begin
            rd_b1 <= wr_b[s_addr[1]] ? mem_b[s_addr[1]] : init_word(s_addr[1]);
         end
      end
   end

   assign s_dout[0] = rd_a;
   assign s_dout[1] = rd_b2;

   // Reference model state
   int                errors = 0;
   int                checks = 0;
   int                cyc    = 0;
   int                m_last;
   int                m_burst;
   bit                m_sticky;
   int                last_g = -1;
   int                dut_g  = -1;
   bit   [DATA_W-1:0] ref_mem [8192];
   bit                ref_wr  [8192];
   int                exp_id  [2][MAX_CYC];
   logic [DATA_W-1:0] exp_dat [2][MAX_CYC];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, act, exp);
      end
   endtask

   // Grant rules stated directly: sticky owner within budget, lone owner, else next valid after owner.
   function automatic int model_grant();
      bit others = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) if (i != m_last && v[i]) others = 1'b1;
      if (m_sticky && v[m_last] && m_burst < MAX_BURST) return m_last;
      if (!others && v[m_last]) return m_last;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (v[(m_last + k) % NUM_REQ]) return (m_last + k) % NUM_REQ;
      end
      return -1;
   endfunction

   function automatic logic [DATA_W-1:0] ref_read(input logic [ADDR_W-1:0] a);
      return ref_wr[a] ? ref_mem[a] : init_word(a);
   endfunction

   // One clock: check outputs at the falling edge, then advance the model at the rising edge.
   task automatic run_cycle();
      int                 g;
      logic [NUM_REQ-1:0] oh;
      logic [NUM_REQ-1:0] ev;
      string              pfx;
      @(negedge clk);
      g  = rst ? -1 : model_grant();
      oh = '0;
      if (g >= 0) oh[g] = 1'b1;
      dut_g = -1;
      for (int i = 0; i < NUM_REQ; i++) if (ready[0][i]) dut_g = i;
      for (int l = 0; l < 2; l++) begin
         pfx = (l == 0) ? "rl1." : "rl2.";
         check({pfx, "req_ready"}, 32'(ready[l]), 32'(oh));
         check({pfx, "sram_en"},   32'(s_en[l]),  (g >= 0) ? 32'd1 : 32'd0);
         check({pfx, "sram_we"},   32'(s_we[l]),  (g >= 0) ? 32'(we[g]) : 32'd0);
         check({pfx, "sram_addr"}, 32'(s_addr[l]), (g >= 0) ? 32'(addr[g]) : 32'd0);
         check({pfx, "sram_din"},  s_din[l],      (g >= 0) ? wd[g] : 32'd0);
         ev = '0;
         if (!rst && exp_id[l][cyc] >= 0) ev[exp_id[l][cyc]] = 1'b1;
         check({pfx, "rsp_valid"}, 32'(rsp_v[l]), 32'(ev));
         if (rst) check({pfx, "rsp_rdata_rst"}, rsp_d[l], 32'd0);
         else if (ev != '0) check({pfx, "rsp_rdata"}, rsp_d[l], exp_dat[l][cyc]);
      end
      @(posedge clk);
      if (rst) begin
         m_last   = NUM_REQ - 1;
         m_burst  = 0;
         m_sticky = 1'b0;
         for (int l = 0; l < 2; l++)
            for (int d = 1; d <= 2; d++)
               if (cyc + d < MAX_CYC) exp_id[l][cyc+d] = -1;
      end else if (g >= 0) begin
         if (g == m_last) m_burst = (m_burst < MAX_BURST) ? m_burst + 1 : MAX_BURST;
         else begin
            m_last  = g;
            m_burst = 1;
         end
         m_sticky = 1'b1;
         if (we[g]) begin
            ref_mem[addr[g]] = wd[g];
            ref_wr[addr[g]]  = 1'b1;
         end else begin
            for (int l = 0; l < 2; l++) begin
               if (cyc + 1 + l < MAX_CYC) begin
                  exp_id[l][cyc+1+l]  = g;
                  exp_dat[l][cyc+1+l] = ref_read(addr[g]);
               end
            end
         end
      end else begin
         m_sticky = 1'b0;
         m_burst  = 0;
      end
      last_g = g;
      cyc++;
      #1;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      v   = '1;
      we  = '0;
      for (int i = 0; i < NUM_REQ; i++) addr[i] = ADDR_W'($urandom_range(8191));
      repeat (n) run_cycle();
      rst = 1'b0;
      v   = '0;
   endtask

   // Random traffic that honours the hold-while-waiting rule but may withdraw a request.
   task automatic rand_drive();
      for (int i = 0; i < NUM_REQ; i++) begin
         if (v[i] && last_g != i) begin
            if ($urandom_range(7) == 0) v[i] = 1'b0;
         end else begin
            v[i]    = ($urandom_range(9) < 7);
            we[i]   = 1'($urandom_range(1));
            addr[i] = ADDR_W'($urandom_range(31));
            wd[i]   = $urandom;
         end
      end
   endtask

   initial begin
      for (int l = 0; l < 2; l++)
         for (int c = 0; c < MAX_CYC; c++) begin
            exp_id[l][c]  = -1;
            exp_dat[l][c] = '0;
         end
      m_last   = NUM_REQ - 1;
      m_burst  = 0;
      m_sticky = 1'b0;
      rst      = 1'b1;
      v        = '0;
      we       = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         addr[i] = '0;
         wd[i]   = '0;
      end

      // Reset with every requester asking: nothing may be granted
      do_reset(2);

      // Single read of the known word
      v[0] = 1'b1; we[0] = 1'b0; addr[0] = 13'h0010;
      run_cycle();
      check("first_read_gnt", 32'(dut_g), 32'd0);
      v = '0;
      repeat (3) run_cycle();

      // All three reading continuously: four-beat bursts in strict rotation
      do_reset(1);
      v = '1; we = '0;
      for (int i = 0; i < NUM_REQ; i++) addr[i] = ADDR_W'($urandom_range(8191));
      for (int c = 0; c < 16; c++) begin
         run_cycle();
         check("burst_seq", 32'(dut_g), 32'((c / 4) % 3));
         if (last_g >= 0) addr[last_g] = ADDR_W'($urandom_range(8191));
      end
      v = '0;
      run_cycle();

      // Lone writer at the top of the address space, then read two of those words back
      for (int c = 0; c < 10; c++) begin
         v = 3'b100; we[2] = 1'b1; addr[2] = ADDR_W'(13'h1FFF - c); wd[2] = $urandom;
         run_cycle();
      end
      v = 3'b001; we[0] = 1'b0; addr[0] = 13'h1FFF;
      run_cycle();
      addr[0] = 13'h1FF6;
      run_cycle();

      // Alternating single-cycle reads from requesters 1 and 0
      we = '0; addr[1] = 13'h0100; addr[0] = 13'h0200;
      for (int c = 0; c < 12; c++) begin
         v = (c % 2 == 0) ? 3'b010 : 3'b001;
         run_cycle();
      end
      v = '0;
      repeat (2) run_cycle();

      // Read in flight when reset hits: it must never be answered
      v = 3'b010; we = '0; addr[1] = 13'h0123;
      run_cycle();
      rst = 1'b1; v = 3'b011; addr[0] = 13'h0042;
      run_cycle();
      rst = 1'b0;
      run_cycle();
      check("post_rst_gnt", 32'(dut_g), 32'd0);
      v = '0;
      repeat (3) run_cycle();

      // Requester 0 pauses mid-burst with nobody else waiting
      we = '0;
      for (int c = 0; c < 8; c++) begin
         v = (c == 3) ? 3'b000 : 3'b001;
         addr[0] = ADDR_W'($urandom_range(8191));
         run_cycle();
      end

      // Randomized mixed traffic
      v = '0;
      for (int c = 0; c < 400; c++) begin
         rand_drive();
         run_cycle();
      end
      v = '0;
      repeat (4) run_cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
